// File: rtl/layer_controller.sv
// layer_controller: runs one shared neuron datapath once per neuron of the layer,
// gathers every activated result into the output vector and flags stalled passes.
module layer_controller #(
  parameter int NUM_NEURONS    = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int INTEGER_WIDTH  = 8,
  parameter int FRACTION_WIDTH = 8,
  localparam int SEL_WIDTH     = $clog2(NUM_NEURONS),
  localparam int DATA_W        = INTEGER_WIDTH + FRACTION_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     neuron_start,
  output logic [SEL_WIDTH-1:0]     neuron_select,
  input  logic signed [DATA_W-1:0] neuron_out,
  input  logic                     neuron_done,
  output logic signed [DATA_W-1:0] out_data [NUM_NEURONS],
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SEL_WIDTH-1:0] SEL_LAST = SEL_WIDTH'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_OUTPUT
  } state_e;

  state_e                   state_q, state_d;
  logic [SEL_WIDTH-1:0]     sel_q, sel_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     timeout_q, timeout_d;
  logic signed [DATA_W-1:0] data_q [NUM_NEURONS];
  logic signed [DATA_W-1:0] data_d [NUM_NEURONS];

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    data_d    = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_START;
          sel_d   = '0;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving on the limit cycle still counts as a good pass.
        if (neuron_done) begin
          data_d[sel_q] = neuron_out;
          if (sel_q == SEL_LAST) begin
            state_d = S_OUTPUT;
          end else begin
            sel_d   = sel_q + 1'b1;
            state_d = S_START;
          end
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_OUTPUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  // Handshake and status outputs depend on the state register alone.
  assign in_ready      = (state_q == S_IDLE);
  assign neuron_start  = (state_q == S_START);
  assign out_valid     = (state_q == S_OUTPUT);
  assign busy          = (state_q != S_IDLE);
  assign neuron_select = sel_q;
  assign timeout       = timeout_q;
  assign out_data      = data_q;

endmodule

// File: tb/tb_layer_controller.sv
// tb_layer_controller: randomized vectors against a schedule-based reference of the
// layer controller, on a 2-neuron and an 8-neuron instance.
module tb_layer_controller;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic use_b;
  logic in_valid, done, out_ready;
  logic signed [DW-1:0] nout;

  logic iv_a, done_a, or_a, iv_b, done_b, or_b;
  assign iv_a   = in_valid & ~use_b;
  assign done_a = done & ~use_b;
  assign or_a   = out_ready & ~use_b;
  assign iv_b   = in_valid & use_b;
  assign done_b = done & use_b;
  assign or_b   = out_ready & use_b;

  logic in_ready_a, start_a, out_valid_a, busy_a, timeout_a;
  logic [0:0] sel_a;
  logic signed [DW-1:0] out_a [2];
  logic in_ready_b, start_b, out_valid_b, busy_b, timeout_b;
  logic [2:0] sel_b;
  logic signed [DW-1:0] out_b [8];

  layer_controller #(.NUM_NEURONS(2), .TIMEOUT_CYCLES(16)) u_dut_a (
    .clock(clk), .reset_n(rst_n), .in_valid(iv_a), .in_ready(in_ready_a),
    .neuron_start(start_a), .neuron_select(sel_a), .neuron_out(nout),
    .neuron_done(done_a), .out_data(out_a), .out_valid(out_valid_a),
    .out_ready(or_a), .busy(busy_a), .timeout(timeout_a)
  );

  layer_controller #(.NUM_NEURONS(8), .TIMEOUT_CYCLES(8)) u_dut_b (
    .clock(clk), .reset_n(rst_n), .in_valid(iv_b), .in_ready(in_ready_b),
    .neuron_start(start_b), .neuron_select(sel_b), .neuron_out(nout),
    .neuron_done(done_b), .out_data(out_b), .out_valid(out_valid_b),
    .out_ready(or_b), .busy(busy_b), .timeout(timeout_b)
  );

  always #5 clk = ~clk;

  logic obs_ready, obs_start, obs_valid, obs_busy, obs_tmo;
  logic [7:0] obs_sel;
  assign obs_ready = use_b ? in_ready_b  : in_ready_a;
  assign obs_start = use_b ? start_b     : start_a;
  assign obs_valid = use_b ? out_valid_b : out_valid_a;
  assign obs_busy  = use_b ? busy_b      : busy_a;
  assign obs_tmo   = use_b ? timeout_b   : timeout_a;
  assign obs_sel   = use_b ? {5'd0, sel_b} : {7'd0, sel_a};

  function automatic logic signed [DW-1:0] obs_out(input int i);
    if (use_b) return out_b[i[2:0]];
    return out_a[i[0]];
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  int dly [8];
  logic signed [DW-1:0] vals [8];
  logic signed [DW-1:0] exp_out [8];
  logic exp_tmo;
  int exp_sel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int n_act();
    return use_b ? 8 : 2;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, obs_ready, 1);
    chk({tag, "_start"}, obs_start, 0);
    chk({tag, "_out_valid"}, obs_valid, 0);
    chk({tag, "_busy"}, obs_busy, 0);
    chk({tag, "_select"}, obs_sel, 0);
    chk({tag, "_timeout"}, obs_tmo, 0);
    for (int i = 0; i < n_act(); i++) chk({tag, "_out_data"}, obs_out(i), 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) exp_out[i] = '0;
    exp_tmo = 1'b0;
    exp_sel = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; done = 1'b0; out_ready = 1'b0;
    #1;
    model_reset();
    chk_reset_vals("por");
    @(negedge clk);
    chk_reset_vals("por_held");
    rst_n = 1'b1;
  endtask

  task automatic rand_vec(input int lo, input int hi);
    for (int i = 0; i < 8; i++) begin
      dly[i]  = $urandom_range(hi, lo);
      vals[i] = 16'($urandom);
    end
  endtask

  task automatic idle_cycles(input int m);
    for (int c = 0; c < m; c++) begin
      @(negedge clk);
      chk("idle_in_ready", obs_ready, 1);
      chk("idle_busy", obs_busy, 0);
      chk("idle_start", obs_start, 0);
      chk("idle_out_valid", obs_valid, 0);
      chk("idle_select", obs_sel, exp_sel);
      chk("idle_timeout", obs_tmo, exp_tmo);
      for (int i = 0; i < n_act(); i++) chk("idle_out_data", obs_out(i), exp_out[i]);
      in_valid = 1'b0;
      done = 1'($urandom_range(1, 0));
      nout = 16'($urandom);
      out_ready = 1'($urandom_range(1, 0));
    end
  endtask

  // Expected timing: accept at cycle 0, neuron i started at a cycle given by the
  // running sum of (1 + d_j); a neuron silent for tl WAIT cycles ends the vector.
  task automatic run_vector(input int hold, input int rst_nrn, input bit spur);
    int n, tl, s, last, e, cur, rst_at;
    int starts [8];
    bit tmo, is_start;
    n = n_act(); tl = use_b ? 8 : 16;
    s = 1; tmo = 1'b0; last = n - 1;
    for (int i = 0; i < 8; i++) starts[i] = -1;
    for (int i = 0; i < n; i++) begin
      if (!tmo) begin
        starts[i] = s;
        if (dly[i] < 1 || dly[i] > tl) begin
          tmo = 1'b1;
          last = i;
        end else begin
          s = s + 1 + dly[i];
        end
      end
    end
    e = tmo ? starts[last] + tl + 1 : s + hold + 1;
    rst_at = (rst_nrn >= 0 && rst_nrn <= last) ? starts[rst_nrn] + 1 : -1;
    for (int k = 0; k < e; k++) begin
      @(negedge clk);
      for (int i = 0; i <= last; i++)
        if (!(tmo && i == last) && k == starts[i] + dly[i] + 1) exp_out[i] = vals[i];
      cur = exp_sel;
      is_start = 1'b0;
      for (int i = 0; i <= last; i++) begin
        if (k > 0 && starts[i] <= k) cur = i;
        if (k > 0 && starts[i] == k) is_start = 1'b1;
      end
      chk("in_ready", obs_ready, k == 0);
      chk("busy", obs_busy, k != 0);
      chk("neuron_start", obs_start, is_start);
      chk("out_valid", obs_valid, !tmo && k >= s);
      chk("neuron_select", obs_sel, cur);
      chk("timeout", obs_tmo, exp_tmo);
      for (int i = 0; i < n; i++) chk("out_data", obs_out(i), exp_out[i]);
      if (k == rst_at) begin
        rst_n = 1'b0; in_valid = 1'b0; done = 1'b0; out_ready = 1'b0;
        #1;
        model_reset();
        chk_reset_vals("midpass_rst");
        @(negedge clk);
        chk_reset_vals("midpass_rst_held");
        rst_n = 1'b1;
        return;
      end
      in_valid  = (k == 0) ? 1'b1 : 1'($urandom_range(1, 0));
      out_ready = (!tmo && k >= s + hold);
      nout = 16'($urandom);
      done = 1'b0;
      for (int i = 0; i <= last; i++)
        if (!(tmo && i == last) && k == starts[i] + dly[i]) begin
          done = 1'b1;
          nout = vals[i];
        end
      if (spur && !done && (k == 0 || is_start || (!tmo && k >= s)))
        done = 1'($urandom_range(1, 0));
    end
    exp_sel = last;
    if (tmo) exp_tmo = 1'b1;
  endtask

  initial begin
    use_b = 1'b0; rst_n = 1'b1; in_valid = 1'b0; done = 1'b0;
    out_ready = 1'b0; nout = '0;
    do_reset();

    // Two-neuron directed vector: 0x0300 then 0x0500, done 3 cycles after each start.
    dly[0] = 3; dly[1] = 3;
    vals[0] = 16'sh0300; vals[1] = 16'sh0500;
    run_vector(0, -1, 1'b0);
    idle_cycles(1);
    chk("req032_word0", obs_out(0), 32'h0300);
    chk("req032_word1", obs_out(1), 32'h0500);

    rand_vec(3, 3);
    run_vector(5, -1, 1'b1);
    for (int v = 0; v < 6; v++) begin
      rand_vec(1, 16);
      run_vector($urandom_range(3, 0), -1, 1'b1);
      if ($urandom_range(1, 0) == 1) idle_cycles($urandom_range(3, 1));
    end
    rand_vec(16, 16);
    run_vector(0, -1, 1'b1);
    idle_cycles(2);

    use_b = 1'b1;
    do_reset();
    for (int v = 0; v < 8; v++) begin
      rand_vec(1, 8);
      run_vector($urandom_range(3, 0), -1, 1'b1);
      if ($urandom_range(1, 0) == 1) idle_cycles($urandom_range(2, 1));
    end
    rand_vec(8, 8);
    run_vector(0, -1, 1'b1);
    idle_cycles(2);

    rand_vec(1, 8);
    dly[0] = 0;
    run_vector(0, -1, 1'b1);
    idle_cycles(2);
    rand_vec(1, 8);
    run_vector(2, -1, 1'b1);
    rand_vec(1, 8);
    dly[5] = 9;
    run_vector(0, -1, 1'b1);
    idle_cycles(1);

    rand_vec(1, 8);
    run_vector(1, 3, 1'b1);
    rand_vec(1, 8);
    run_vector(0, -1, 1'b1);
    idle_cycles(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end within the time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
